tsi_core: RTL and testbench



---
 rtl/tswitch_pkg.sv | 15 +
 rtl/tsi_conn_mem.sv | 82 ++++++++
 rtl/tsi_core.sv | 105 ++++++++++
 tb/tb_tsi_core.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tswitch_pkg.sv
// Shared types and constants for the time-slot interchange core.
// Connection entries are sized for the largest supported frame (128 slots).
package tswitch_pkg;
   localparam int MAX_SLOT_W = 7;

   localparam logic [7:0] REG_STATUS   = 8'hFE;
   localparam logic [7:0] REG_NSLOTS   = 8'hFF;
   localparam logic [7:0] DEFAULT_IDLE = 8'hD5;

   // One byte per output slot; matches the register read-back layout {en, 0.., src}.
   typedef struct packed {
      logic                  en;
      logic [MAX_SLOT_W-1:0] src;
   } conn_entry_t;
endpackage

// File: rtl/tsi_conn_mem.sv
// Shadow/active connection memory with register decode; shadow writes land on the access edge,
// commit copies shadow (including a coincident write) to active in one cycle; reads registered, never stall.
module tsi_conn_mem
   import tswitch_pkg::*;
#(
   parameter int N_SLOTS = 32,
   parameter int SLOT_W  = $clog2(N_SLOTS)
) (
   input  logic              clk_system,
   input  logic              rst_n,
   input  logic [7:0]        ctrl_reg_addr,
   input  logic [7:0]        ctrl_reg_wdata,
   input  logic              ctrl_reg_rd,
   input  logic              ctrl_reg_en,
   output logic [7:0]        ctrl_reg_rdata,
   input  logic              commit,
   input  logic              sync_err,
   output logic              sync_err_clr,
   input  logic [SLOT_W-1:0] lookup_slot,
   output conn_entry_t       lookup_entry
);
   localparam logic [7:0] LAST_ADDR = 8'(N_SLOTS - 1);

   conn_entry_t       shadow [N_SLOTS];
   conn_entry_t       active [N_SLOTS];
   conn_entry_t       wr_entry;
   conn_entry_t       shadow_at_lookup;
   logic [SLOT_W-1:0] idx;
   logic              in_map;
   logic              wr_hit;
   logic              pending;
   logic [7:0]        rd_mux;
   logic              unused_wdata;

   assign idx          = ctrl_reg_addr[SLOT_W-1:0];
   assign in_map       = (ctrl_reg_addr <= LAST_ADDR);
   assign wr_hit       = ctrl_reg_en && !ctrl_reg_rd && in_map;
   assign sync_err_clr = ctrl_reg_en && ctrl_reg_rd && (ctrl_reg_addr == REG_STATUS);
   assign unused_wdata = ^ctrl_reg_wdata;

   always_comb begin
      wr_entry                 = '0;
      wr_entry.en              = ctrl_reg_wdata[7];
      wr_entry.src[SLOT_W-1:0] = ctrl_reg_wdata[SLOT_W-1:0];
   end

   // On a commit strobe the datapath must already see the entry that becomes active.
   always_comb begin
      shadow_at_lookup = shadow[lookup_slot];
      if (wr_hit && idx == lookup_slot) shadow_at_lookup = wr_entry;
      lookup_entry = commit ? shadow_at_lookup : active[lookup_slot];
   end

   always_comb begin
      pending = 1'b0;
      for (int i = 0; i < N_SLOTS; i++)
         if (shadow[i] != active[i]) pending = 1'b1;
   end

   always_comb begin
      rd_mux = '0;
      if (in_map)                              rd_mux = shadow[idx];
      else if (ctrl_reg_addr == REG_STATUS)    rd_mux = {6'b0, pending, sync_err};
      else if (ctrl_reg_addr == REG_NSLOTS)    rd_mux = LAST_ADDR;
   end

   always_ff @(posedge clk_system) begin
      if (!rst_n) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         ctrl_reg_rdata <= '0;
      end else begin
         if (wr_hit) shadow[idx] <= wr_entry;
         if (commit)
            for (int i = 0; i < N_SLOTS; i++)
               active[i] <= (wr_hit && idx == SLOT_W'(i)) ? wr_entry : shadow[i];
         if (ctrl_reg_en && ctrl_reg_rd) ctrl_reg_rdata <= rd_mux;
      end
   end
endmodule

// File: rtl/tsi_core.sv
// Time-slot interchange: double-buffered speech memory read through the connection map, one-frame delay.
// Output registered one cycle after slot_strobe; no backpressure, control accesses never stall the datapath.
module tsi_core
   import tswitch_pkg::*;
#(
   parameter int                      N_SLOTS      = 32,
   parameter int                      SAMPLE_W     = 8,
   parameter logic [SAMPLE_W-1:0]     IDLE_PATTERN = SAMPLE_W'(DEFAULT_IDLE)
) (
   input  logic                          clk_system,
   input  logic                          rst_n,
   input  logic                          slot_strobe,
   input  logic                          frame_sync,
   input  logic [SAMPLE_W-1:0]           in_data,
   output logic [SAMPLE_W-1:0]           out_data,
   output logic                          out_valid,
   output logic [$clog2(N_SLOTS)-1:0]    out_slot,
   input  logic [7:0]                    ctrl_reg_addr,
   input  logic [7:0]                    ctrl_reg_wdata,
   output logic [7:0]                    ctrl_reg_rdata,
   input  logic                          ctrl_reg_rd,
   input  logic                          ctrl_reg_en
);
   localparam int                SLOT_W    = $clog2(N_SLOTS);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);
   localparam logic [7:0]        N_SLOTS_B = 8'(N_SLOTS);

   logic [SAMPLE_W-1:0] speech [2][N_SLOTS];
   logic [SLOT_W-1:0]   count, count_nxt;
   logic                wr_page, page_nxt;
   logic                first_sync, primed, primed_nxt;
   logic                sync_err, err_set, err_clr;
   logic                commit;
   conn_entry_t         entry;
   logic [SLOT_W-1:0]   rd_src;
   logic                route_ok;

   assign commit   = slot_strobe && frame_sync;
   assign rd_src   = entry.src[SLOT_W-1:0];
   assign route_ok = primed_nxt && entry.en && ({1'b0, entry.src} < N_SLOTS_B);

   always_comb begin
      count_nxt  = count;
      page_nxt   = wr_page;
      primed_nxt = primed;
      err_set    = 1'b0;
      if (slot_strobe) begin
         if (frame_sync) begin
            count_nxt  = '0;
            page_nxt   = ~wr_page;
            primed_nxt = primed || first_sync;
            err_set    = (count != LAST_SLOT);
         end else if (count == LAST_SLOT) begin
            count_nxt = '0;
            err_set   = 1'b1;
         end else begin
            count_nxt = count + SLOT_W'(1);
         end
      end
   end

   tsi_conn_mem #(.N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W)) u_conn_mem (
      .clk_system     (clk_system),
      .rst_n          (rst_n),
      .ctrl_reg_addr  (ctrl_reg_addr),
      .ctrl_reg_wdata (ctrl_reg_wdata),
      .ctrl_reg_rd    (ctrl_reg_rd),
      .ctrl_reg_en    (ctrl_reg_en),
      .ctrl_reg_rdata (ctrl_reg_rdata),
      .commit         (commit),
      .sync_err       (sync_err),
      .sync_err_clr   (err_clr),
      .lookup_slot    (count_nxt),
      .lookup_entry   (entry)
   );

   // The write page and the read page always differ, so no read/write collision.
   always_ff @(posedge clk_system) begin
      if (rst_n && slot_strobe) speech[page_nxt][count_nxt] <= in_data;
   end

   always_ff @(posedge clk_system) begin
      if (!rst_n) begin
         count      <= '0;
         wr_page    <= 1'b0;
         first_sync <= 1'b0;
         primed     <= 1'b0;
         sync_err   <= 1'b0;
         out_valid  <= 1'b0;
         out_slot   <= '0;
         out_data   <= IDLE_PATTERN;
      end else begin
         count      <= count_nxt;
         wr_page    <= page_nxt;
         primed     <= primed_nxt;
         first_sync <= first_sync || commit;
         sync_err   <= err_set || (sync_err && !err_clr);
         out_valid  <= slot_strobe;
         if (slot_strobe) begin
            out_slot <= count_nxt;
            out_data <= route_ok ? speech[~page_nxt][rd_src] : IDLE_PATTERN;
         end
      end
   end
endmodule

// File: tb/tb_tsi_core.sv
// Randomised bench for tsi_core: a 32x8 and a 128x16 instance checked against a frame-level model.
`timescale 1ns/1ps
module tb_tsi_core;
   logic clk_system = 1'b0;
   always #5 clk_system = ~clk_system;

   logic        rst_n, strobe, fsync, sel, rd, en;
   logic [15:0] din;
   logic [7:0]  addr, wdata;

   logic [7:0]  a_data, a_rdata, b_rdata;
   logic [15:0] b_data;
   logic        a_valid, b_valid;
   logic [4:0]  a_slot;
   logic [6:0]  b_slot;

   tsi_core #(.N_SLOTS(32), .SAMPLE_W(8)) dut_a (
      .clk_system (clk_system), .rst_n (rst_n),
      .slot_strobe (strobe & ~sel), .frame_sync (fsync), .in_data (din[7:0]),
      .out_data (a_data), .out_valid (a_valid), .out_slot (a_slot),
      .ctrl_reg_addr (addr), .ctrl_reg_wdata (wdata), .ctrl_reg_rdata (a_rdata),
      .ctrl_reg_rd (rd), .ctrl_reg_en (en & ~sel)
   );

   tsi_core #(.N_SLOTS(128), .SAMPLE_W(16)) dut_b (
      .clk_system (clk_system), .rst_n (rst_n),
      .slot_strobe (strobe & sel), .frame_sync (fsync), .in_data (din),
      .out_data (b_data), .out_valid (b_valid), .out_slot (b_slot),
      .ctrl_reg_addr (addr), .ctrl_reg_wdata (wdata), .ctrl_reg_rdata (b_rdata),
      .ctrl_reg_rd (rd), .ctrl_reg_en (en & sel)
   );

   logic [31:0] o_data, o_slot, o_rdata;
   logic        o_valid;
   assign o_data  = sel ? 32'(b_data)  : 32'(a_data);
   assign o_slot  = sel ? 32'(b_slot)  : 32'(a_slot);
   assign o_rdata = sel ? 32'(b_rdata) : 32'(a_rdata);
   assign o_valid = sel ? b_valid : a_valid;

   // Reference model: register file, two frame buffers, slot position, sync bookkeeping.
   int ns, smask, slot_w;
   int sh [128];
   int ac [128];
   int cur [128];
   int prv [128];
   int cnt, syncs;
   bit serr;
   bit fixed;
   int n_tests, n_fail;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic set_cfg(input bit b);
      sel    = b;
      ns     = b ? 128 : 32;
      smask  = b ? 'hFFFF : 'hFF;
      slot_w = b ? 7 : 5;
   endtask

   function automatic int entry_of(input int d);
      return (d & 'h80) | (d & ((1 << slot_w) - 1));
   endfunction

   task automatic do_reset();
      @(negedge clk_system);
      rst_n = 1'b0; strobe = 1'b0; en = 1'b0;
      @(posedge clk_system); #1;
      cnt = 0; syncs = 0; serr = 1'b0;
      for (int i = 0; i < 128; i++) begin sh[i] = 0; ac[i] = 0; end
      check("rst_out_data",  o_data,  32'hD5);
      check("rst_out_valid", o_valid, 0);
      check("rst_out_slot",  o_slot,  0);
      check("rst_rdata",     o_rdata, 0);
      @(negedge clk_system);
      rst_n = 1'b1;
   endtask

   // One strobe, optionally with a concurrent control write.
   task automatic slot(input bit fs, input int data, input bit wen, input int wa, input int wd);
      int e, src, exp;
      @(negedge clk_system);
      strobe = 1'b1; fsync = fs; din = 16'(data);
      en = wen; rd = 1'b0; addr = 8'(wa); wdata = 8'(wd);
      @(posedge clk_system); #1;
      if (wen && wa < ns) sh[wa] = entry_of(wd);
      if (fs) begin
         if (cnt != ns - 1) serr = 1'b1;
         cnt = 0;
         syncs++;
         for (int i = 0; i < 128; i++) begin
            e = cur[i]; cur[i] = prv[i]; prv[i] = e;
            ac[i] = sh[i];
         end
      end else if (cnt == ns - 1) begin
         serr = 1'b1;
         cnt  = 0;
      end else begin
         cnt++;
      end
      cur[cnt] = data & smask;
      e   = ac[cnt];
      src = e & 'h7F;
      exp = (syncs >= 2 && e[7] && src < ns) ? prv[src] : 'hD5;
      check("out_valid", o_valid, 1);
      check("out_slot",  o_slot,  cnt);
      check("out_data",  o_data,  exp);
   endtask

   task automatic idle();
      @(negedge clk_system);
      strobe = 1'b0; en = 1'b0;
      @(posedge clk_system); #1;
      check("idle_valid", o_valid, 0);
   endtask

   task automatic reg_wr(input int a, input int d);
      @(negedge clk_system);
      strobe = 1'b0; en = 1'b1; rd = 1'b0; addr = 8'(a); wdata = 8'(d);
      @(posedge clk_system); #1;
      if (a < ns) sh[a] = entry_of(d);
   endtask

   task automatic reg_rd(input int a);
      int exp;
      bit pend;
      @(negedge clk_system);
      strobe = 1'b0; en = 1'b1; rd = 1'b1; addr = 8'(a);
      @(posedge clk_system); #1;
      pend = 1'b0;
      for (int i = 0; i < ns; i++) if (sh[i] != ac[i]) pend = 1'b1;
      if (a < ns)         exp = sh[a];
      else if (a == 'hFE) begin exp = (int'(pend) << 1) | int'(serr); serr = 1'b0; end
      else if (a == 'hFF) exp = ns - 1;
      else                exp = 0;
      check($sformatf("rd_%02h", a), o_rdata, exp);
   endtask

   function automatic int gen(input int s);
      if (fixed && s == 1) return 'h55;
      if (fixed && s == 2) return 'h56;
      return int'($urandom & 32'hFFFF);
   endfunction

   // n strobes, the first optionally carrying frame_sync; gaps and side writes are random.
   task automatic run_slots(input bit first_sync, input int n, input bit gaps, input bit side_wr);
      bit fs, w;
      int nxt;
      for (int k = 0; k < n; k++) begin
         fs  = first_sync && (k == 0);
         nxt = fs ? 0 : (cnt + 1) % ns;
         w   = side_wr && ($urandom_range(0, 7) == 0);
         slot(fs, gen(nxt), w, int'($urandom_range(0, ns - 1)), int'($urandom & 32'hFF));
         if (gaps && $urandom_range(0, 3) == 0) idle();
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0; fixed = 1'b0;
      rst_n = 1'b0; strobe = 1'b0; fsync = 1'b0; rd = 1'b0; en = 1'b0;
      din = '0; addr = '0; wdata = '0;
      for (int i = 0; i < 128; i++) begin cur[i] = 0; prv[i] = 0; end
      set_cfg(1'b0);
      do_reset();

      // Route and delay
      reg_wr('h12, 'h81);
      reg_wr('h13, 'h82);
      reg_rd('hFE);
      fixed = 1'b1;
      repeat (4) run_slots(1'b1, ns, 1'b0, 1'b0);

      // Atomic commit mid-frame
      run_slots(1'b1, 16, 1'b1, 1'b0);
      reg_wr('h12, 'h82);
      reg_rd('hFE);
      run_slots(1'b0, ns - 16, 1'b0, 1'b0);
      run_slots(1'b1, ns, 1'b0, 1'b0);
      reg_rd('hFE);
      fixed = 1'b0;

      // Sync errors: early sync, then a wrap without sync
      reg_rd('hFE);
      reg_rd('hFE);
      run_slots(1'b1, 11, 1'b0, 1'b0);
      run_slots(1'b1, ns, 1'b0, 1'b0);
      reg_rd('hFE);
      reg_rd('hFE);
      run_slots(1'b0, 5, 1'b0, 1'b0);
      reg_rd('hFE);
      reg_rd('hFE);
      run_slots(1'b1, ns, 1'b0, 1'b0);

      // Readback and address boundaries
      reg_wr('h05, 'h87);
      reg_rd('h05);
      reg_rd('hFF);
      reg_rd('h40);
      reg_rd('h20);
      reg_rd('h1F);
      reg_wr('hFE, 'hFF);
      reg_rd('hFE);

      // Random tables, data, gaps and concurrent writes
      for (int f = 0; f < 8; f++) begin
         repeat (4) reg_wr(int'($urandom_range(0, 255)), int'($urandom & 32'hFF));
         repeat (6) reg_wr(int'($urandom_range(0, ns - 1)), int'($urandom & 32'hFF));
         reg_rd(int'($urandom_range(0, ns - 1)));
         reg_rd('hFE);
         run_slots(1'b1, ns, 1'b1, 1'b1);
      end
      reg_rd('hFE);

      // Reset mid-frame at count 17, then priming restarts
      run_slots(1'b1, 18, 1'b0, 1'b0);
      do_reset();
      reg_rd('h12);
      reg_rd('hFE);
      run_slots(1'b0, 14, 1'b0, 1'b0);
      run_slots(1'b1, ns, 1'b0, 1'b0);
      reg_wr('h03, 'h81);
      reg_wr('h00, 'h9F);
      run_slots(1'b1, ns, 1'b0, 1'b0);
      run_slots(1'b1, ns, 1'b0, 1'b0);
      run_slots(1'b1, ns, 1'b1, 1'b0);

      // Wide configuration: reverse mapping with back-to-back strobes
      set_cfg(1'b1);
      do_reset();
      for (int k = 0; k < 128; k++) reg_wr(k, 'h80 | (127 - k));
      reg_rd('hFF);
      reg_rd('h7F);
      reg_rd('hFE);
      repeat (4) run_slots(1'b1, ns, 1'b0, 1'b0);
      reg_rd('hFE);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
